kamus_lsu: RTL and testbench

Load/store unit on the data side of the kamus-v core. It consumes the memory-stage request qualified by the control unit's l1d_wr_en and load strobes, and drives the L1D request/grant/response bus. It handles byte-lane alignment, load sign and zero extension, misalignment detection, bus timeout and pipeline stall. It sits between the EX/MEM pipeline register and the L1D port.

---
 rtl/kamus_pkg.sv | 38 +++
 rtl/kamus_lsu_align.sv | 54 +++++
 rtl/kamus_lsu.sv | 149 ++++++++++++++
 tb/tb_kamus_lsu.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kamus_pkg.sv
// Shared types for the kamus-v data-side load/store path.
package kamus_pkg;

    localparam int KAMUS_XLEN = 32;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_REQ,
        LSU_RESP
    } lsu_state_e;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_size_e;

    typedef struct packed {
        logic                  we;
        logic [KAMUS_XLEN-1:0] addr;
        logic [KAMUS_XLEN-1:0] wdata;
        mem_size_e             size;
    } lsu_req_t;

    // Reserved encodings 011/110/111 fall back to a full-word access.
    function automatic mem_size_e decode_size(input logic [2:0] funct3);
        case (funct3)
            3'b000:  return MEM_B;
            3'b001:  return MEM_H;
            3'b100:  return MEM_BU;
            3'b101:  return MEM_HU;
            default: return MEM_W;
        endcase
    endfunction

endpackage

// File: rtl/kamus_lsu_align.sv
// Combinational lane logic: byte enables, store replication, load extract/extend
// and misalignment detection.
module kamus_lsu_align
    import kamus_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  mem_size_e       req_size,
    input  logic [1:0]      req_offset,
    input  logic [XLEN-1:0] req_wdata,
    input  mem_size_e       rsp_size,
    input  logic [1:0]      rsp_offset,
    input  logic [XLEN-1:0] rsp_word,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wdata_rep,
    output logic [XLEN-1:0] ld_data,
    output logic            misaligned
);

    logic [XLEN-1:0] shifted;

    assign shifted = rsp_word >> {rsp_offset, 3'b000};

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        be         = 4'b1111;
        wdata_rep  = req_wdata;
        misaligned = 1'b0;
        unique case (req_size)
            MEM_B, MEM_BU: begin
                be        = 4'b0001 << req_offset;
                wdata_rep = {(XLEN/8){req_wdata[7:0]}};
            end
            MEM_H, MEM_HU: begin
                be         = 4'b0011 << req_offset;
                wdata_rep  = {(XLEN/16){req_wdata[15:0]}};
                misaligned = req_offset[0];
            end
            default: misaligned = |req_offset;
        endcase
    end

    always_comb begin
        ld_data = shifted;
        unique case (rsp_size)
            MEM_B:   ld_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            MEM_BU:  ld_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
            MEM_H:   ld_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            MEM_HU:  ld_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
            default: ld_data = shifted;
        endcase
    end

endmodule

// File: rtl/kamus_lsu.sv
// kamus-v load/store unit: request FSM, bus timeout and payload registers
// between the EX/MEM register and the L1D request/grant/response port.
module kamus_lsu
    import kamus_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    input  logic            l1d_wr_en_i,
    input  logic            load_en_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [2:0]      funct3_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] rdata_o,
    output logic            misaligned_o,
    output logic            bus_err_o,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [3:0]      mem_be_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    lsu_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    mem_size_e       size_q;
    logic [1:0]      off_q;
    lsu_req_t        req;
    logic            access;
    logic            expire;
    logic            mis;
    logic [3:0]      be;
    logic [XLEN-1:0] wdata_rep;
    logic [XLEN-1:0] ld_data;

    always_comb begin
        req.we    = l1d_wr_en_i;
        req.addr  = addr_i;
        req.wdata = wdata_i;
        req.size  = decode_size(funct3_i);
    end

    assign access = req_valid_i && (l1d_wr_en_i || load_en_i);
    assign expire = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    kamus_lsu_align #(.XLEN(XLEN)) u_align (
        .req_size   (req.size),
        .req_offset (req.addr[1:0]),
        .req_wdata  (req.wdata),
        .rsp_size   (size_q),
        .rsp_offset (off_q),
        .rsp_word   (mem_rdata_i),
        .be         (be),
        .wdata_rep  (wdata_rep),
        .ld_data    (ld_data),
        .misaligned (mis)
    );

    always_comb begin
        state_d      = state_q;
        stall_o      = 1'b0;
        done_o       = 1'b0;
        misaligned_o = 1'b0;
        bus_err_o    = 1'b0;
        unique case (state_q)
            LSU_IDLE: begin
                if (access && mis) begin
                    misaligned_o = 1'b1;
                end else if (access) begin
                    stall_o = 1'b1;
                    state_d = LSU_REQ;
                end
            end
            LSU_REQ: begin
                stall_o = 1'b1;
                if (expire) begin
                    bus_err_o = 1'b1;
                    state_d   = LSU_IDLE;
                end else if (mem_gnt_i) begin
                    state_d = LSU_RESP;
                end
            end
            LSU_RESP: begin
                // A response landing on the expiry cycle still completes.
                if (mem_rvalid_i) begin
                    done_o  = 1'b1;
                    state_d = LSU_IDLE;
                end else begin
                    stall_o = 1'b1;
                    if (expire) begin
                        bus_err_o = 1'b1;
                        state_d   = LSU_IDLE;
                    end
                end
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    assign rdata_o = (done_o && !mem_we_o) ? ld_data : '0;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= LSU_IDLE;
            cnt_q       <= '0;
            size_q      <= MEM_B;
            off_q       <= 2'b00;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_be_o    <= 4'b0000;
            mem_wdata_o <= '0;
        end else begin
            state_q <= state_d;

            if (state_d == LSU_IDLE) begin
                cnt_q <= '0;
            end else if (state_q != LSU_IDLE) begin
                cnt_q <= cnt_q + 1'b1;
            end

            if (state_q == LSU_IDLE && state_d == LSU_REQ) begin
                mem_req_o   <= 1'b1;
                mem_we_o    <= req.we;
                mem_addr_o  <= {req.addr[XLEN-1:2], 2'b00};
                mem_be_o    <= be;
                mem_wdata_o <= wdata_rep;
                size_q      <= req.size;
                off_q       <= req.addr[1:0];
            end else if (state_q == LSU_REQ && state_d != LSU_REQ) begin
                mem_req_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_kamus_lsu.sv
// Self-checking bench for kamus_lsu: table-driven accesses with a scoreboard
// of expected bus payloads and load results, plus timeout and reset sequences.
module tb_kamus_lsu;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        l1d_wr_en_i = 1'b0;
    logic        load_en_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic [2:0]  funct3_i = 3'b000;
    logic        stall_o, done_o, misaligned_o, bus_err_o;
    logic [31:0] rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;

    kamus_lsu #(.XLEN(32), .TIMEOUT_CYCLES(8)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .l1d_wr_en_i  (l1d_wr_en_i),
        .load_en_i    (load_en_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .funct3_i     (funct3_i),
        .stall_o      (stall_o),
        .done_o       (done_o),
        .rdata_o      (rdata_o),
        .misaligned_o (misaligned_o),
        .bus_err_o    (bus_err_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_be_o     (mem_be_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        we;
        logic        both;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          gnt_dly;
        logic [31:0] rword;
        logic        mis;
        logic [3:0]  be;
        logic [31:0] mwdata;
        logic [31:0] rdata;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic we, input logic both, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input int gnt_dly, input logic [31:0] rword, input logic mis,
                                input logic [3:0] be, input logic [31:0] mwdata,
                                input logic [31:0] rdata);
        vec_t v;
        v.we = we; v.both = both; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.gnt_dly = gnt_dly; v.rword = rword; v.mis = mis; v.be = be;
        v.mwdata = mwdata; v.rdata = rdata;
        vecs.push_back(v);
    endfunction

    task automatic drive_req(input logic we, input logic both, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata);
        req_valid_i = 1'b1;
        l1d_wr_en_i = we;
        load_en_i   = both || !we;
        addr_i      = addr;
        wdata_i     = wdata;
        funct3_i    = f3;
    endtask

    task automatic drop_req();
        req_valid_i = 1'b0;
        l1d_wr_en_i = 1'b0;
        load_en_i   = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        @(negedge clk_i);
        drive_req(v.we, v.both, v.f3, v.addr, v.wdata);
        #1;
        if (v.mis) begin
            check("misaligned_o", misaligned_o, 1);
            check("mis_stall_o", stall_o, 0);
            @(posedge clk_i);
            #1;
            drop_req();
            #1;
            check("mis_mem_req_o", mem_req_o, 0);
            check("mis_pulse_end", misaligned_o, 0);
            return;
        end
        check("idle_stall_o", stall_o, 1);
        check("idle_misaligned_o", misaligned_o, 0);
        e.addr = v.addr & 32'hFFFF_FFFC;
        e.we = v.we;
        e.be = v.be;
        e.wdata = v.mwdata;
        e.rdata = v.rdata;
        sb.push_back(e);
        @(posedge clk_i);
        #1;
        drop_req();
        for (int i = 0; i <= v.gnt_dly; i++) begin
            check("mem_req_o", mem_req_o, 1);
            check("mem_addr_o", mem_addr_o, sb[0].addr);
            check("mem_be_o", mem_be_o, sb[0].be);
            check("mem_we_o", mem_we_o, sb[0].we);
            check("mem_wdata_o", mem_wdata_o, sb[0].wdata);
            check("req_stall_o", stall_o, 1);
            if (i == v.gnt_dly) mem_gnt_i = 1'b1;
            @(posedge clk_i);
            #1;
            mem_gnt_i = 1'b0;
        end
        check("resp_mem_req_o", mem_req_o, 0);
        check("resp_done_o", done_o, 0);
        check("resp_stall_o", stall_o, 1);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = v.rword;
        #1;
        check("done_o", done_o, 1);
        check("done_stall_o", stall_o, 0);
        check("done_bus_err_o", bus_err_o, 0);
        e = sb.pop_front();
        check("rdata_o", rdata_o, e.rdata);
        @(posedge clk_i);
        #1;
        mem_rvalid_i = 1'b0;
        #1;
        check("after_done_o", done_o, 0);
        check("after_stall_o", stall_o, 0);
    endtask

    task automatic timeout_seq();
        int k;
        bit seen;
        seen = 1'b0;
        @(negedge clk_i);
        drive_req(1'b0, 1'b0, 3'b010, 32'h0000_B000, 32'h0);
        @(posedge clk_i);
        #1;
        drop_req();
        for (k = 1; k <= 20; k++) begin
            check("to_mem_req_o", mem_req_o, 1);
            check("to_stall_o", stall_o, 1);
            if (bus_err_o) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk_i);
            #1;
        end
        check("timeout_seen", seen, 1);
        check("timeout_cycle", k, 8);
        @(posedge clk_i);
        #1;
        check("to_idle_mem_req_o", mem_req_o, 0);
        check("to_idle_stall_o", stall_o, 0);
        check("to_idle_bus_err_o", bus_err_o, 0);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hBAD0_BAD0;
        #1;
        check("stray_done_o", done_o, 0);
        check("stray_rdata_o", rdata_o, 0);
        check("stray_stall_o", stall_o, 0);
        @(posedge clk_i);
        #1;
        mem_rvalid_i = 1'b0;
        check("stray_mem_req_o", mem_req_o, 0);
        check("stray_bus_err_o", bus_err_o, 0);
    endtask

    task automatic reset_in_resp_seq();
        vec_t v;
        @(negedge clk_i);
        drive_req(1'b0, 1'b0, 3'b010, 32'h0000_C000, 32'h0);
        @(posedge clk_i);
        #1;
        drop_req();
        mem_gnt_i = 1'b1;
        @(posedge clk_i);
        #1;
        mem_gnt_i = 1'b0;
        check("rst_pre_stall_o", stall_o, 1);
        rst_i = 1'b1;
        #1;
        check("rst_mem_req_o", mem_req_o, 0);
        check("rst_stall_o", stall_o, 0);
        check("rst_mem_addr_o", mem_addr_o, 0);
        check("rst_mem_be_o", mem_be_o, 0);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h7777_7777;
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("rst_late_done_o", done_o, 0);
        check("rst_late_rdata_o", rdata_o, 0);
        @(posedge clk_i);
        #1;
        mem_rvalid_i = 1'b0;
        check("rst_late_stall_o", stall_o, 0);
        check("rst_late_mem_req_o", mem_req_o, 0);
        v.we = 1'b0; v.both = 1'b0; v.f3 = 3'b010; v.addr = 32'h0000_E000;
        v.wdata = 32'h0; v.gnt_dly = 1; v.rword = 32'h1357_9BDF; v.mis = 1'b0;
        v.be = 4'b1111; v.mwdata = 32'h0; v.rdata = 32'h1357_9BDF;
        run_vec(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        //   we    both  f3      addr          wdata         dly rword         mis   be       mwdata        rdata
        add(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0000_00A5, 0, 32'hFFFF_FFFF, 1'b0, 4'b1000, 32'hA5A5_A5A5, 32'h0);
        add(1'b0, 1'b0, 3'b000, 32'h0000_2002, 32'h0,         0, 32'h12F0_3456, 1'b0, 4'b0100, 32'h0,         32'hFFFF_FFF0);
        add(1'b0, 1'b0, 3'b100, 32'h0000_2002, 32'h0,         0, 32'h12F0_3456, 1'b0, 4'b0100, 32'h0,         32'h0000_00F0);
        add(1'b0, 1'b0, 3'b001, 32'h0000_2002, 32'h0,         0, 32'h12F0_3456, 1'b0, 4'b1100, 32'h0,         32'h0000_12F0);
        add(1'b0, 1'b0, 3'b001, 32'h0000_2000, 32'h0,         1, 32'h0001_8001, 1'b0, 4'b0011, 32'h0,         32'hFFFF_8001);
        add(1'b0, 1'b0, 3'b101, 32'h0000_2002, 32'h0,         0, 32'h8001_0000, 1'b0, 4'b1100, 32'h0,         32'h0000_8001);
        add(1'b0, 1'b0, 3'b010, 32'h0000_3001, 32'h0,         0, 32'h0,         1'b1, 4'b0000, 32'h0,         32'h0);
        add(1'b1, 1'b0, 3'b001, 32'h0000_3001, 32'h0000_1111, 0, 32'h0,         1'b1, 4'b0000, 32'h0,         32'h0);
        add(1'b0, 1'b0, 3'b010, 32'h0000_4000, 32'h0,         4, 32'hDEAD_BEEF, 1'b0, 4'b1111, 32'h0,         32'hDEAD_BEEF);
        add(1'b1, 1'b0, 3'b001, 32'h0000_5002, 32'h1234_ABCD, 1, 32'hFFFF_FFFF, 1'b0, 4'b1100, 32'hABCD_ABCD, 32'h0);
        add(1'b1, 1'b0, 3'b010, 32'h0000_6000, 32'hCAFE_F00D, 2, 32'hFFFF_FFFF, 1'b0, 4'b1111, 32'hCAFE_F00D, 32'h0);
        add(1'b0, 1'b0, 3'b000, 32'h0000_7001, 32'h0,         0, 32'h0000_7F00, 1'b0, 4'b0010, 32'h0,         32'h0000_007F);
        add(1'b0, 1'b0, 3'b011, 32'h0000_8000, 32'h0,         0, 32'h1122_3344, 1'b0, 4'b1111, 32'h0,         32'h1122_3344);
        add(1'b0, 1'b0, 3'b001, 32'h0000_8003, 32'h0,         0, 32'h0,         1'b1, 4'b0000, 32'h0,         32'h0);
        add(1'b0, 1'b0, 3'b110, 32'h0000_8002, 32'h0,         0, 32'h0,         1'b1, 4'b0000, 32'h0,         32'h0);
        add(1'b0, 1'b0, 3'b101, 32'h0000_2001, 32'h0,         0, 32'h0,         1'b1, 4'b0000, 32'h0,         32'h0);
        add(1'b1, 1'b1, 3'b000, 32'h0000_9000, 32'h0000_005A, 0, 32'hFFFF_FFFF, 1'b0, 4'b0001, 32'h5A5A_5A5A, 32'h0);
        add(1'b0, 1'b0, 3'b100, 32'h0000_A003, 32'h0,         0, 32'h8000_0000, 1'b0, 4'b1000, 32'h0,         32'h0000_0080);
        add(1'b0, 1'b0, 3'b010, 32'h0000_D000, 32'h0,         6, 32'h0BAD_F00D, 1'b0, 4'b1111, 32'h0,         32'h0BAD_F00D);

        #12;
        check("reset_mem_req_o", mem_req_o, 0);
        check("reset_mem_we_o", mem_we_o, 0);
        check("reset_mem_be_o", mem_be_o, 0);
        check("reset_mem_addr_o", mem_addr_o, 0);
        check("reset_mem_wdata_o", mem_wdata_o, 0);
        check("reset_stall_o", stall_o, 0);
        check("reset_done_o", done_o, 0);
        check("reset_rdata_o", rdata_o, 0);
        check("reset_misaligned_o", misaligned_o, 0);
        check("reset_bus_err_o", bus_err_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);

        foreach (vecs[i]) run_vec(vecs[i]);

        timeout_seq();
        reset_in_resp_seq();

        check("scoreboard_empty", sb.size(), 0);
        repeat (2) @(negedge clk_i);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
